regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a pending-write scoreboard, the successor to the single-write, two-read register file in the RISC-V core. It serves the decode/issue stage with any number of combinational read ports, accepts several writeback ports per cycle, optionally forwards same-cycle writeback data to readers, and tracks which registers have an in-flight producer so issue logic can detect RAW hazards.

---
 rtl/regfile_pkg.sv | 37 +++
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_mp.sv | 134 +++++++++++++
 tb/tb_regfile_mp.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and write-port priority resolution for the multi-port register file.
package regfile_pkg;

  localparam int RF_DW        = 32;
  localparam int RF_WORDS     = 32;
  localparam int RF_ADDRW     = $clog2(RF_WORDS);
  localparam int RF_MAX_NWR   = 8;
  localparam int RF_MAX_ADDRW = 16;
  localparam int RF_PORTW     = $clog2(RF_MAX_NWR);

  typedef logic [RF_DW-1:0]    rf_data_t;
  typedef logic [RF_ADDRW-1:0] rf_addr_t;

  typedef struct packed {
    logic                hit;
    logic [RF_PORTW-1:0] port;
  } rf_hit_t;

  // Later ports overwrite earlier matches, so the highest enabled index wins.
  function automatic rf_hit_t rf_resolve(
    input logic [RF_MAX_ADDRW-1:0]            addr,
    input logic [RF_MAX_NWR-1:0]              en,
    input logic [RF_MAX_NWR*RF_MAX_ADDRW-1:0] waddr
  );
    rf_hit_t r;
    r.hit  = 1'b0;
    r.port = '0;
    for (int unsigned p = 0; p < RF_MAX_NWR; p++) begin
      if (en[p] && (waddr[p*RF_MAX_ADDRW +: RF_MAX_ADDRW] == addr)) begin
        r.hit  = 1'b1;
        r.port = RF_PORTW'(p);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit array tracking registers with an in-flight producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int WORDS    = 32,
  parameter int ADDRW    = $clog2(WORDS),
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en_i,
  input  logic [ADDRW-1:0] set_addr_i,
  input  logic [WORDS-1:0] clr_i,
  input  logic             flush_i,
  output logic [WORDS-1:0] busy_o
);

  logic [WORDS-1:0] r_busy;
  logic [WORDS-1:0] w_busy_nxt;
  logic [31:0]      w_set_a32;

  // Priority per bit: flush, then set (new producer), then clear.
  always_comb begin
    w_busy_nxt = r_busy;
    w_set_a32  = 32'(set_addr_i);
    for (int unsigned w = 0; w < WORDS; w++) begin
      if (flush_i) begin
        w_busy_nxt[w] = 1'b0;
      end else if (set_en_i && (w_set_a32 == w)) begin
        w_busy_nxt[w] = 1'b1;
      end else if (clr_i[w]) begin
        w_busy_nxt[w] = 1'b0;
      end
    end
    if (ZERO_REG != 0) begin
      w_busy_nxt[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign busy_o = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NWR write ports, NRD combinational read ports,
// optional same-cycle write forwarding and a RAW-hazard scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DW       = 32,
  parameter int WORDS    = 32,
  parameter int ADDRW    = $clog2(WORDS),
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*ADDRW-1:0] rd_addr_i,
  output logic [NRD*DW-1:0]    rd_data_o,
  output logic [NRD-1:0]       rd_busy_o,
  input  logic [NWR-1:0]       wr_en_i,
  input  logic [NWR*ADDRW-1:0] wr_addr_i,
  input  logic [NWR*DW-1:0]    wr_data_i,
  input  logic                 sb_set_en_i,
  input  logic [ADDRW-1:0]     sb_set_addr_i,
  input  logic                 flush_i
);

  function automatic logic [DW-1:0] sel_port(
    input logic [RF_PORTW-1:0] port,
    input logic [NWR*DW-1:0]   data
  );
    logic [DW-1:0] d;
    d = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      if (RF_PORTW'(p) == port) begin
        d = data[p*DW +: DW];
      end
    end
    return d;
  endfunction

  logic [RF_MAX_NWR-1:0]              w_en_ext;
  logic [RF_MAX_NWR*RF_MAX_ADDRW-1:0] w_addr_ext;
  logic [DW-1:0]                      r_mem  [WORDS];
  logic [DW-1:0]                      w_wsel [WORDS];
  logic [WORDS-1:0]                   w_hit;
  logic [WORDS-1:0]                   w_busy;

  // Widen the write ports to the fixed shape the shared resolver expects.
  always_comb begin
    w_en_ext   = '0;
    w_addr_ext = '0;
    for (int unsigned p = 0; p < NWR; p++) begin
      w_en_ext[p] = wr_en_i[p];
      w_addr_ext[p*RF_MAX_ADDRW +: RF_MAX_ADDRW] = RF_MAX_ADDRW'(wr_addr_i[p*ADDRW +: ADDRW]);
    end
  end

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    rf_hit_t w_res;
    always_comb w_res = rf_resolve(RF_MAX_ADDRW'(w), w_en_ext, w_addr_ext);
    assign w_hit[w]  = w_res.hit;
    assign w_wsel[w] = sel_port(w_res.port, wr_data_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned w = 0; w < WORDS; w++) begin
        r_mem[w] <= '0;
      end
    end else begin
      for (int unsigned w = 0; w < WORDS; w++) begin
        if (w_hit[w] && !((ZERO_REG != 0) && (w == 0))) begin
          r_mem[w] <= w_wsel[w];
        end
      end
    end
  end

  regfile_scoreboard #(
    .WORDS    (WORDS),
    .ADDRW    (ADDRW),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (sb_set_en_i),
    .set_addr_i (sb_set_addr_i),
    .clr_i      (w_hit),
    .flush_i    (flush_i),
    .busy_o     (w_busy)
  );

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [ADDRW-1:0] w_addr;
    logic [31:0]      w_a32;
    logic             w_valid;
    logic [DW-1:0]    w_store;
    logic             w_sbusy;
    logic [DW-1:0]    w_rdata;
    logic             w_rbusy;
    rf_hit_t          w_byp;

    // Out-of-range and hardwired-zero addresses never forward, read 0 and are never busy.
    always_comb begin
      w_addr  = rd_addr_i[r*ADDRW +: ADDRW];
      w_a32   = 32'(w_addr);
      w_valid = (w_a32 < 32'(WORDS)) && !((ZERO_REG != 0) && (w_addr == '0));
      w_store = '0;
      w_sbusy = 1'b0;
      for (int unsigned w = 0; w < WORDS; w++) begin
        if (w_a32 == w) begin
          w_store = r_mem[w];
          w_sbusy = w_busy[w];
        end
      end
      w_byp   = rf_resolve(RF_MAX_ADDRW'(w_addr), w_en_ext, w_addr_ext);
      w_rdata = '0;
      w_rbusy = 1'b0;
      if (w_valid) begin
        if ((BYPASS != 0) && w_byp.hit) begin
          w_rdata = sel_port(w_byp.port, wr_data_i);
          w_rbusy = 1'b0;
        end else begin
          w_rdata = w_store;
          w_rbusy = w_sbusy;
        end
      end
    end

    assign rd_data_o[r*DW +: DW] = w_rdata;
    assign rd_busy_o[r]          = w_rbusy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: vector table on a 2-write bypassing 24-word instance,
// hand sequences on a 1-write non-bypassing instance incl. async reset.
module tb_regfile_mp;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  // Instance A: 32 words, NWR=1, BYPASS=0
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [0:0]  a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_set_en;
  logic [4:0]  a_set_addr;
  logic        a_flush;

  // Instance B: 24 words, NWR=2, BYPASS=1
  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr;
  logic [63:0] b_wr_data;
  logic        b_set_en;
  logic [4:0]  b_set_addr;
  logic        b_flush;

  regfile_mp #(
    .DW(32), .WORDS(32), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(1)
  ) u_a (
    .clk(clk), .rst(rst),
    .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data), .rd_busy_o(a_rd_busy),
    .wr_en_i(a_wr_en), .wr_addr_i(a_wr_addr), .wr_data_i(a_wr_data),
    .sb_set_en_i(a_set_en), .sb_set_addr_i(a_set_addr), .flush_i(a_flush)
  );

  regfile_mp #(
    .DW(32), .WORDS(24), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)
  ) u_b (
    .clk(clk), .rst(rst),
    .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data), .rd_busy_o(b_rd_busy),
    .wr_en_i(b_wr_en), .wr_addr_i(b_wr_addr), .wr_data_i(b_wr_data),
    .sb_set_en_i(b_set_en), .sb_set_addr_i(b_set_addr), .flush_i(b_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        se;
    logic [4:0]  sa;
    logic        fl;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        eb0;
    logic        eb1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1,
    input logic se, input logic [4:0] sa, input logic fl,
    input logic [4:0] ra0, input logic [4:0] ra1,
    input logic [31:0] ed0, input logic [31:0] ed1, input logic eb0, input logic eb1
  );
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.se = se; v.sa = sa; v.fl = fl; v.ra0 = ra0; v.ra1 = ra1;
    v.ed0 = ed0; v.ed1 = ed1; v.eb0 = eb0; v.eb1 = eb1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic apply_b(input vec_t v);
    b_wr_en    = v.we;
    b_wr_addr  = {v.wa1, v.wa0};
    b_wr_data  = {v.wd1, v.wd0};
    b_set_en   = v.se;
    b_set_addr = v.sa;
    b_flush    = v.fl;
    b_rd_addr  = {v.ra1, v.ra0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    a_rd_addr = '0; a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0;
    a_set_en = 1'b0; a_set_addr = '0; a_flush = 1'b0;
    b_rd_addr = '0; b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0;
    b_set_en = 1'b0; b_set_addr = '0; b_flush = 1'b0;

    //         we wa0 wd0            wa1 wd1            se sa  fl ra0 ra1 ed0            ed1            eb0 eb1
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 3,  9,  0,             0,             0, 0));
    tbl.push_back(mk(3, 3, 32'hAAAA0000, 3, 32'h0000BBBB, 0, 0,  0, 3,  3,  32'h0000BBBB,  32'h0000BBBB,  0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 3,  3,  32'h0000BBBB,  32'h0000BBBB,  0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 9,  0, 9,  3,  0,             32'h0000BBBB,  0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 9,  9,  0,             0,             1, 1));
    tbl.push_back(mk(1, 9, 32'h55,       0, 0,            0, 0,  0, 9,  3,  32'h55,        32'h0000BBBB,  0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 9,  9,  32'h55,        32'h55,        0, 0));
    tbl.push_back(mk(2, 0, 0,            4, 32'h44,       1, 4,  0, 4,  0,  32'h44,        0,             0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 4,  4,  32'h44,        32'h44,        1, 1));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 4,  1, 4,  9,  32'h44,        32'h55,        1, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 4,  4,  32'h44,        32'h44,        0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0,  0, 0,  0,  0,             0,             0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 0,  4,  0,             32'h44,        0, 0));
    tbl.push_back(mk(3, 30, 32'hDEAD0030, 0, 32'h11111111, 0, 0, 0, 30, 0,  0,             0,             0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 14, 6,  0,             0,             0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            1, 30, 0, 30, 0,  0,             0,             0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 30, 23, 0,             0,             0, 0));
    tbl.push_back(mk(3, 10, 32'h1010,    11, 32'h1111,    0, 0,  0, 10, 11, 32'h1010,      32'h1111,      0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 11, 10, 32'h1111,      32'h1010,      0, 0));
    tbl.push_back(mk(2, 0, 0,            23, 32'h23232323, 1, 23, 0, 23, 22, 32'h23232323, 0,             0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 23, 23, 32'h23232323,  32'h23232323,  1, 1));
    tbl.push_back(mk(1, 23, 32'h77,      0, 0,            1, 9,  0, 23, 9,  32'h77,        32'h55,        0, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 23, 9,  32'h77,        32'h55,        0, 1));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  1, 9,  23, 32'h55,        32'h77,        1, 0));
    tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0,  0, 9,  23, 32'h55,        32'h77,        0, 0));

    repeat (2) @(negedge clk);
    rst = 1'b0;

    // reset state on both instances
    a_rd_addr = {5'd5, 5'd0};
    b_rd_addr = {5'd23, 5'd3};
    #1;
    chk("rst.a.d0", a_rd_data[31:0], 32'h0);
    chk("rst.a.d1", a_rd_data[63:32], 32'h0);
    chk("rst.a.busy", 32'(a_rd_busy), 32'h0);
    chk("rst.b.d0", b_rd_data[31:0], 32'h0);
    chk("rst.b.busy", 32'(b_rd_busy), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply_b(tbl[i]);
      #1;
      chk($sformatf("b[%0d].d0", i), b_rd_data[31:0], tbl[i].ed0);
      chk($sformatf("b[%0d].d1", i), b_rd_data[63:32], tbl[i].ed1);
      chk($sformatf("b[%0d].busy0", i), 32'(b_rd_busy[0]), 32'(tbl[i].eb0));
      chk($sformatf("b[%0d].busy1", i), 32'(b_rd_busy[1]), 32'(tbl[i].eb1));
    end
    @(negedge clk);
    b_wr_en = '0; b_set_en = 1'b0; b_flush = 1'b0;

    // write latency without bypass
    a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h12345678;
    a_rd_addr = {5'd0, 5'd7};
    #1 chk("a.nobyp", a_rd_data[31:0], 32'h0);
    @(negedge clk);
    a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF;
    #1 chk("a.wr7", a_rd_data[31:0], 32'h12345678);
    @(negedge clk);
    a_wr_en = 1'b0;
    #1;
    chk("a.x0", a_rd_data[63:32], 32'h0);
    chk("a.x7keep", a_rd_data[31:0], 32'h12345678);

    // scoreboard without bypass: clear visible only after the edge
    a_set_en = 1'b1; a_set_addr = 5'd9; a_rd_addr = {5'd9, 5'd9};
    #1 chk("a.set.same", 32'(a_rd_busy[0]), 32'h0);
    @(negedge clk);
    a_set_en = 1'b0;
    #1 chk("a.set.next", 32'(a_rd_busy[0]), 32'h1);
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h55;
    #1;
    chk("a.clr.same.busy", 32'(a_rd_busy[1]), 32'h1);
    chk("a.clr.same.data", a_rd_data[31:0], 32'h0);
    @(negedge clk);
    a_wr_en = 1'b0;
    #1;
    chk("a.clr.next.busy", 32'(a_rd_busy[0]), 32'h0);
    chk("a.clr.next.data", a_rd_data[31:0], 32'h55);

    // asynchronous reset between edges
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
    a_set_en = 1'b1; a_set_addr = 5'd6;
    @(negedge clk);
    a_wr_en = 1'b0; a_set_en = 1'b0;
    a_rd_addr = {5'd6, 5'd5};
    b_rd_addr = {5'd3, 5'd3};
    #1;
    chk("a.pre.d5", a_rd_data[31:0], 32'hDEADBEEF);
    chk("a.pre.busy6", 32'(a_rd_busy[1]), 32'h1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst.d5", a_rd_data[31:0], 32'h0);
    chk("arst.busy6", 32'(a_rd_busy[1]), 32'h0);
    chk("arst.b.x3", b_rd_data[31:0], 32'h0);
    a_wr_en = 1'b1; a_wr_addr = 5'd8; a_wr_data = 32'h88;
    a_rd_addr = {5'd6, 5'd8};
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel.before", a_rd_data[31:0], 32'h0);
    @(negedge clk);
    a_wr_en = 1'b0;
    #1;
    chk("rel.after", a_rd_data[31:0], 32'h88);
    chk("rel.busy6", 32'(a_rd_busy[1]), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
